// File: rtl/sram_pkg.sv
// Shared constants and lane helpers for the 1R1W SRAM model.
// Helpers operate on maximum-width words; callers size-cast to and from their own widths.
package sram_pkg;

  localparam int unsigned BYPASS_READ_OLD      = 0;
  localparam int unsigned BYPASS_WRITE_THROUGH = 1;

  localparam int unsigned MaxDataWidth = 1024;
  localparam int unsigned MaxLanes     = 128;

  typedef logic [MaxDataWidth-1:0] word_max_t;
  typedef logic [MaxLanes-1:0]     mask_max_t;

  function automatic int unsigned lane_width(input int unsigned data_width,
                                             input int unsigned wmask_width);
    return (wmask_width == 0) ? 0 : data_width / wmask_width;
  endfunction

  // Lanes selected by mask come from new_word; all other bits keep old_word.
  function automatic word_max_t lane_merge(input word_max_t   old_word,
                                           input word_max_t   new_word,
                                           input mask_max_t   mask,
                                           input int unsigned lw);
    word_max_t lane_ones;
    word_max_t bit_mask;
    lane_ones = (word_max_t'(1) << lw) - word_max_t'(1);
    bit_mask  = '0;
    for (int unsigned l = 0; l < MaxLanes; l++) begin
      if (((mask >> l) & mask_max_t'(1)) != '0) begin
        bit_mask = bit_mask | (lane_ones << (l * lw));
      end
    end
    return (old_word & ~bit_mask) | (new_word & bit_mask);
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-return pipeline of 1 or 2 register stages carrying {data, valid, collision}.
// Data registers load only on a valid beat, so the output word holds between reads.
module sram_rd_pipe #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  collision_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  collision_o
);

  logic                  s1_valid_q;
  logic                  s1_coll_q;
  logic [DATA_WIDTH-1:0] s1_data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_coll_q  <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= valid_i;
      s1_coll_q  <= collision_i & valid_i;
      if (valid_i) begin
        s1_data_q <= data_i;
      end
    end
  end

  if (READ_LATENCY == 2) begin : gen_two_stage
    logic                  s2_valid_q;
    logic                  s2_coll_q;
    logic [DATA_WIDTH-1:0] s2_data_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        s2_valid_q <= 1'b0;
        s2_coll_q  <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        s2_coll_q  <= s1_coll_q;
        if (s1_valid_q) begin
          s2_data_q <= s1_data_q;
        end
      end
    end

    assign valid_o     = s2_valid_q;
    assign collision_o = s2_coll_q;
    assign data_o      = s2_data_q;
  end else begin : gen_one_stage
    assign valid_o     = s1_valid_q;
    assign collision_o = s1_coll_q;
    assign data_o      = s1_data_q;
  end

endmodule

// File: rtl/sram_1r1w_bypass.sv
// Single-clock 1W/1R SRAM model with lane write masks, 1- or 2-cycle read latency,
// selectable read-during-write policy and saturating collision accounting.
module sram_1r1w_bypass
  import sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned WMASK_WIDTH  = 4,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned BYPASS_MODE  = 0,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input  logic                   clk0,
  input  logic                   rst,
  input  logic                   csb0,
  input  logic [WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0]  din0,
  input  logic                   csb1,
  input  logic [ADDR_WIDTH-1:0]  addr1,
  output logic [DATA_WIDTH-1:0]  dout1,
  output logic                   dout1_valid,
  output logic                   collision,
  output logic [CNT_WIDTH-1:0]   collision_count
);

  localparam int unsigned Depth     = 2 ** ADDR_WIDTH;
  localparam int unsigned LaneWidth = lane_width(DATA_WIDTH, WMASK_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : gen_bad_latency
    $error("sram_1r1w_bypass: READ_LATENCY must be 1 or 2");
  end
  if (WMASK_WIDTH == 0 || (DATA_WIDTH % WMASK_WIDTH) != 0) begin : gen_bad_lanes
    $error("sram_1r1w_bypass: DATA_WIDTH must be a multiple of WMASK_WIDTH");
  end
  if (DATA_WIDTH > MaxDataWidth || WMASK_WIDTH > MaxLanes) begin : gen_too_wide
    $error("sram_1r1w_bypass: DATA_WIDTH or WMASK_WIDTH exceeds package maximum");
  end
  if (BYPASS_MODE != BYPASS_READ_OLD && BYPASS_MODE != BYPASS_WRITE_THROUGH) begin : gen_bad_bypass
    $error("sram_1r1w_bypass: BYPASS_MODE must be 0 or 1");
  end

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  logic                  wr_en;
  logic                  rd_en;
  logic                  collide;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rd_old;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  pipe_coll;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [CNT_WIDTH-1:0]  count_d;

  assign wr_en   = ~csb0 & (|wmask0);
  assign rd_en   = ~csb1;
  assign collide = wr_en & rd_en & (addr0 == addr1);

  assign wr_word = DATA_WIDTH'(lane_merge(word_max_t'(mem_q[addr0]), word_max_t'(din0),
                                          mask_max_t'(wmask0), LaneWidth));
  assign rd_old  = mem_q[addr1];

  // On a collision addr0 == addr1, so the merged write word is exactly the write-through value.
  assign rd_data = (BYPASS_MODE == BYPASS_WRITE_THROUGH && collide) ? wr_word : rd_old;

  always_ff @(posedge clk0) begin
    if (!rst && wr_en) begin
      mem_q[addr0] <= wr_word;
    end
  end

  sram_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_pipe (
    .clk_i      (clk0),
    .rst_i      (rst),
    .valid_i    (rd_en),
    .data_i     (rd_data),
    .collision_i(collide),
    .valid_o    (dout1_valid),
    .data_o     (dout1),
    .collision_o(pipe_coll)
  );

  assign collision = pipe_coll;

  always_comb begin
    count_d = count_q;
    if (pipe_coll && count_q != CntMax) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk0) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign collision_count = count_q;

endmodule
